// File: rtl/gpu_pipe_pkg.sv
// Shared types and constants for the pixel pipe fetch stage.
package gpu_pipe_pkg;

    localparam int unsigned ADDR_W         = 26;
    localparam int unsigned RAM_DW         = 16;
    localparam int unsigned FLASH_DW       = 8;
    localparam int unsigned TIMEOUT_CYCLES = 255;

    localparam logic [15:0] TRANSPARENT = '0;

    typedef enum logic [1:0] {
        IDLE,
        RAM_RD,
        FLASH_RD,
        OUTPUT
    } fetch_state_t;

endpackage

// File: rtl/mem_req_port.sv
// Single-outstanding read request port: holds req/addr until ack.
// Optional wait-timeout counter under PIXEL_FETCH_TIMEOUT_EN.
module mem_req_port #(
    parameter int unsigned AW = 26
`ifdef PIXEL_FETCH_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          ack,
    output logic          req,
    output logic [AW-1:0] addr,
    output logic          done,
    output logic          timeout
);

    // An ack only counts while a request is outstanding.
    assign done = req & ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            req  <= 1'b0;
            addr <= '0;
        end else if (start) begin
            req  <= 1'b1;
            addr <= start_addr;
        end else if (done || timeout) begin
            req  <= 1'b0;
        end
    end

`ifdef PIXEL_FETCH_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of completed cycles the current req has waited.
    assign timeout = req & ~ack & (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || start) begin
            cnt <= '0;
        end else if (req && !ack) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: rtl/pixel_fetch.sv
// Pipe stage 3: fetches a layer pixel (sprite colour or text glyph bit) from RAM/flash.
// Optional ack timeout via PIXEL_FETCH_TIMEOUT_EN.
module pixel_fetch #(
    parameter int unsigned ADDR_W   = gpu_pipe_pkg::ADDR_W,
    parameter int unsigned RAM_DW   = gpu_pipe_pkg::RAM_DW,
    parameter int unsigned FLASH_DW = gpu_pipe_pkg::FLASH_DW
`ifdef PIXEL_FETCH_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = gpu_pipe_pkg::TIMEOUT_CYCLES
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_layer_id,
    input  logic                in_ram_en,
    input  logic                in_flash_en,
    input  logic [ADDR_W-1:0]   in_ram_off,
    input  logic [ADDR_W-1:0]   in_flash_bits,
    input  logic [ADDR_W-1:0]   in_ram_base,
    input  logic [15:0]         in_glyph_bits,
    input  logic [15:0]         in_text_color,
    output logic                ram_req,
    output logic [ADDR_W-1:0]   ram_addr,
    input  logic                ram_ack,
    input  logic [RAM_DW-1:0]   ram_rdata,
    output logic                flash_req,
    output logic [ADDR_W-4:0]   flash_addr,
    input  logic                flash_ack,
    input  logic [FLASH_DW-1:0] flash_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_layer_id,
    output logic [15:0]         out_color,
    output logic                out_opaque,
    output logic                fetch_err
);
    import gpu_pipe_pkg::*;

    fetch_state_t        state;
    logic                flash_en_q;
    logic [ADDR_W-1:0]   flash_bits_q;
    logic [15:0]         glyph_q;
    logic [15:0]         text_color_q;
    logic [2:0]          bitsel;
    logic [ADDR_W-1:0]   bitaddr;
    logic                ram_start, ram_done, ram_timeout;
    logic                flash_start, flash_done, flash_timeout;
    logic                glyph_bit;

    assign in_ready = (state == IDLE);

    // Glyph bit address: 32-bit char*glyph product, truncated to the address width.
    assign bitaddr     = flash_bits_q + ADDR_W'(32'(ram_rdata) * 32'(glyph_q));
    assign ram_start   = (state == IDLE) && in_valid && in_ram_en;
    assign flash_start = (state == RAM_RD) && ram_done && flash_en_q;
    assign glyph_bit   = flash_rdata[3'd7 - bitsel];

    mem_req_port #(
        .AW(ADDR_W)
`ifdef PIXEL_FETCH_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
    ) u_ram_port (
        .clk        (clk),
        .rst        (rst),
        .start      (ram_start),
        .start_addr (in_ram_base + in_ram_off),
        .ack        (ram_ack),
        .req        (ram_req),
        .addr       (ram_addr),
        .done       (ram_done),
        .timeout    (ram_timeout)
    );

    mem_req_port #(
        .AW(ADDR_W - 3)
`ifdef PIXEL_FETCH_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
    ) u_flash_port (
        .clk        (clk),
        .rst        (rst),
        .start      (flash_start),
        .start_addr (bitaddr[ADDR_W-1:3]),
        .ack        (flash_ack),
        .req        (flash_req),
        .addr       (flash_addr),
        .done       (flash_done),
        .timeout    (flash_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            flash_en_q   <= 1'b0;
            flash_bits_q <= '0;
            glyph_q      <= '0;
            text_color_q <= '0;
            bitsel       <= '0;
            out_valid    <= 1'b0;
            out_layer_id <= '0;
            out_color    <= '0;
            out_opaque   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        flash_en_q   <= in_flash_en;
                        flash_bits_q <= in_flash_bits;
                        glyph_q      <= in_glyph_bits;
                        text_color_q <= in_text_color;
                        out_layer_id <= in_layer_id;
                        if (in_ram_en) begin
                            state <= RAM_RD;
                        end else begin
                            out_color  <= TRANSPARENT;
                            out_opaque <= 1'b0;
                            out_valid  <= 1'b1;
                            state      <= OUTPUT;
                        end
                    end
                end
                RAM_RD: begin
                    if (ram_done) begin
                        if (flash_en_q) begin
                            bitsel <= bitaddr[2:0];
                            state  <= FLASH_RD;
                        end else begin
                            out_color  <= 16'(ram_rdata);
                            out_opaque <= 1'b1;
                            out_valid  <= 1'b1;
                            state      <= OUTPUT;
                        end
                    end else if (ram_timeout) begin
                        out_color  <= TRANSPARENT;
                        out_opaque <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= OUTPUT;
                    end
                end
                FLASH_RD: begin
                    if (flash_done) begin
                        out_color  <= glyph_bit ? text_color_q : TRANSPARENT;
                        out_opaque <= glyph_bit;
                        out_valid  <= 1'b1;
                        state      <= OUTPUT;
                    end else if (flash_timeout) begin
                        out_color  <= TRANSPARENT;
                        out_opaque <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PIXEL_FETCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_err <= 1'b0;
        end else if (ram_timeout || flash_timeout) begin
            fetch_err <= 1'b1;
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

endmodule
